// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM: one byte-enable write port (A), one read port (B) on a
// single clock. It has a selectable read latency (1 or 2), a configurable
// same-address collision policy and a read-data valid strobe. An optional
// post-reset sequencer zeroes the whole array before normal traffic is accepted.
module ram_sdp_be #(
    parameter int DATAWIDTH    = 32,
    parameter int ADDRWIDTH    = 10,
    parameter int READLATENCY  = 1,
    parameter int RDWRMODE     = 0,
    parameter int CLEARONRESET = 1
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [ADDRWIDTH-1:0]   PortAAddr,
    input  logic [DATAWIDTH-1:0]   PortADataIn,
    input  logic                   PortAWriteEnable,
    input  logic [DATAWIDTH/8-1:0] PortAByteEnable,
    input  logic [ADDRWIDTH-1:0]   PortBAddr,
    input  logic                   PortBReadEnable,
    output logic [DATAWIDTH-1:0]   PortBDataOut,
    output logic                   PortBDataValid,
    output logic                   InitBusy
);

    localparam int MEMDEPTH = 2 ** ADDRWIDTH;
    localparam int NBYTES   = DATAWIDTH / 8;

    // Unsupported parameter combinations stop elaboration with an error.
    if ((READLATENCY != 1) && (READLATENCY != 2)) begin : g_bad_latency
        $error("ram_sdp_be: READLATENCY must be 1 or 2");
    end
    if ((DATAWIDTH % 8) != 0) begin : g_bad_width
        $error("ram_sdp_be: DATAWIDTH must be a multiple of 8");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Per-byte merge: take the new byte where the enable bit is set, keep the old one elsewhere.
    function automatic logic [DATAWIDTH-1:0] merge_bytes(
        input logic [DATAWIDTH-1:0] old_word,
        input logic [DATAWIDTH-1:0] new_word,
        input logic [NBYTES-1:0]    byte_en
    );
        logic [DATAWIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_en[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                result[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    logic [DATAWIDTH-1:0] r_mem [MEMDEPTH];
    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDRWIDTH-1:0] r_cnt;
    logic                 r_init_busy;
    logic                 w_clr_fire;
    logic                 w_wr_fire;
    logic                 w_rd_fire;
    logic                 w_collide;
    logic [DATAWIDTH-1:0] w_rd_old;
    logic [DATAWIDTH-1:0] w_rd_data;
    logic [DATAWIDTH-1:0] r_dout;
    logic                 r_dvalid;

    // Traffic qualifiers: host ports are live only in IDLE, and nothing fires while Rst is high.
    always_comb begin
        w_clr_fire = (r_state == ST_CLEAR) && !Rst;
        w_wr_fire  = (r_state == ST_IDLE) && !Rst && PortAWriteEnable;
        w_rd_fire  = (r_state == ST_IDLE) && !Rst && PortBReadEnable;
        w_collide  = w_wr_fire && (PortAAddr == PortBAddr);
        w_rd_old   = r_mem[PortBAddr];
        if ((RDWRMODE == 1) && w_collide) begin
            w_rd_data = merge_bytes(w_rd_old, PortADataIn, PortAByteEnable);
        end else begin
            w_rd_data = w_rd_old;
        end
    end

    // Clear sequencer next state: leave CLEAR once the last address has been zeroed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_IDLE;
            ST_CLEAR: begin
                if (r_cnt == ADDRWIDTH'(MEMDEPTH - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State, clear address counter and busy flag; Rst restarts the clear from address 0.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= (CLEARONRESET == 1) ? ST_CLEAR : ST_IDLE;
            r_init_busy <= (CLEARONRESET == 1) ? 1'b1 : 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_busy <= (w_state_nxt == ST_CLEAR);
            if (r_state == ST_CLEAR) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Array writes: clear zeroes one word per cycle, otherwise byte-masked port A writes.
    always_ff @(posedge Clk) begin
        if (w_clr_fire) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_fire) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (PortAByteEnable[i]) begin
                    r_mem[PortAAddr][8*i +: 8] <= PortADataIn[8*i +: 8];
                end
            end
        end
    end

    if (READLATENCY == 2) begin : g_lat2
        logic [DATAWIDTH-1:0] r_s1_data;
        logic                 r_s1_vld;

        // Two-stage read: collision already resolved into stage 1, stage 2 only delays.
        always_ff @(posedge Clk) begin
            if (Rst) begin
                r_s1_data <= '0;
                r_s1_vld  <= 1'b0;
                r_dout    <= '0;
                r_dvalid  <= 1'b0;
            end else begin
                r_s1_vld <= w_rd_fire;
                if (w_rd_fire) begin
                    r_s1_data <= w_rd_data;
                end
                r_dvalid <= r_s1_vld;
                if (r_s1_vld) begin
                    r_dout <= r_s1_data;
                end
            end
        end
    end else begin : g_lat1
        // Single-stage read: output register loads directly from the array.
        always_ff @(posedge Clk) begin
            if (Rst) begin
                r_dout   <= '0;
                r_dvalid <= 1'b0;
            end else begin
                r_dvalid <= w_rd_fire;
                if (w_rd_fire) begin
                    r_dout <= w_rd_data;
                end
            end
        end
    end

    assign PortBDataOut   = r_dout;
    assign PortBDataValid = r_dvalid;
    assign InitBusy       = r_init_busy;

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be. Two instances share the same stimulus: one with
// READLATENCY=2 / read-first, one with READLATENCY=1 / write-first. A queue-based
// reference model predicts every output each cycle; directed table rows also
// carry hand-computed read results.
module tb_ram_sdp_be;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic          a_we;
    logic [3:0]    a_be;
    logic [AW-1:0] b_addr;
    logic          b_re;
    logic [DW-1:0] dout0, dout1;
    logic          vld0, vld1, busy0, busy1;

    always #5 Clk = ~Clk;

    ram_sdp_be #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .READLATENCY(2), .RDWRMODE(0), .CLEARONRESET(1)) dut0 (
        .Clk(Clk), .Rst(Rst), .PortAAddr(a_addr), .PortADataIn(a_din), .PortAWriteEnable(a_we),
        .PortAByteEnable(a_be), .PortBAddr(b_addr), .PortBReadEnable(b_re),
        .PortBDataOut(dout0), .PortBDataValid(vld0), .InitBusy(busy0));

    ram_sdp_be #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .READLATENCY(1), .RDWRMODE(1), .CLEARONRESET(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .PortAAddr(a_addr), .PortADataIn(a_din), .PortAWriteEnable(a_we),
        .PortAByteEnable(a_be), .PortBAddr(b_addr), .PortBReadEnable(b_re),
        .PortBDataOut(dout1), .PortBDataValid(vld1), .InitBusy(busy1));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    typedef struct { int due; logic [31:0] data; } rd_t;
    logic [31:0] m_mem [DEPTH];
    bit          m_busy = 1'b1;
    int          m_cnt  = 0;
    int          cyc    = 0;
    rd_t         q0[$], q1[$];
    logic [31:0] last0 = 32'h0, last1 = 32'h0;
    logic [31:0] cq0[$], cq1[$];

    typedef struct {
        bit          we;
        logic [3:0]  aa;
        logic [31:0] din;
        logic [3:0]  be;
        bit          re;
        logic [3:0]  ba;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model of one clock edge, using the inputs as they stand just before it.
    task automatic model_edge();
        logic [31:0] old_w, new_w;
        cyc++;
        if (Rst) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            q0.delete(); q1.delete();
            last0 = 32'h0; last1 = 32'h0;
        end else if (m_busy) begin
            m_mem[m_cnt] = 32'h0;
            if (m_cnt == DEPTH - 1) m_busy = 1'b0;
            m_cnt = (m_cnt + 1) % DEPTH;
        end else begin
            if (b_re) begin
                old_w = m_mem[b_addr];
                new_w = (a_we && a_addr == b_addr) ? merge(old_w, a_din, a_be) : old_w;
                q0.push_back('{due: cyc + 1, data: old_w});   // latency 2, read-first
                q1.push_back('{due: cyc,     data: new_w});   // latency 1, write-first
            end
            if (a_we) m_mem[a_addr] = merge(m_mem[a_addr], a_din, a_be);
        end
    endtask

    task automatic compare();
        bit ev0, ev1;
        ev0 = (q0.size() > 0) && (q0[0].due == cyc);
        ev1 = (q1.size() > 0) && (q1[0].due == cyc);
        if (ev0) last0 = q0.pop_front().data;
        if (ev1) last1 = q1.pop_front().data;
        check("valid0", {31'd0, vld0}, {31'd0, ev0});
        check("valid1", {31'd0, vld1}, {31'd0, ev1});
        check("dout0", dout0, last0);
        check("dout1", dout1, last1);
        check("busy0", {31'd0, busy0}, {31'd0, m_busy});
        check("busy1", {31'd0, busy1}, {31'd0, m_busy});
        if (vld0 && cq0.size() > 0) check("dir0", dout0, cq0.pop_front());
        if (vld1 && cq1.size() > 0) check("dir1", dout1, cq1.pop_front());
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        compare();
    endtask

    task automatic drive(input bit rst, input bit we, input logic [3:0] aa, input logic [31:0] din,
                         input logic [3:0] be, input bit re, input logic [3:0] ba);
        Rst = rst; a_we = we; a_addr = aa; a_din = din; a_be = be; b_re = re; b_addr = ba;
    endtask

    task automatic count_clear(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 40 && busy0; i++) begin
            tick();
            n++;
        end
        check(name, n, 32'd16);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        drive(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);

        // Clear sequence, with a write and read to addr 2 held during CLEAR
        tick(); tick();
        drive(1'b0, 1'b1, 4'd2, 32'hDEADBEEF, 4'hF, 1'b1, 4'd2);
        count_clear("clear_len");
        drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        tick();

        // Every address reads back zero
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a));
            cq0.push_back(32'h0); cq1.push_back(32'h0);
            tick();
        end
        drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        tick(); tick(); tick();

        // Reset mid-clear restarts a full clear
        drive(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        count_clear("clear_restart_len");
        tick();

        // Directed table: byte enables, latency/throughput, collisions
        tbl.push_back('{1'b1, 4'd3, 32'hAABBCCDD, 4'hF, 1'b0, 4'd0, 32'h0, 32'h0});
        tbl.push_back('{1'b1, 4'd3, 32'h11223344, 4'h5, 1'b0, 4'd0, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd3, 32'hAA22CC44, 32'hAA22CC44});
        tbl.push_back('{1'b1, 4'd3, 32'h55555555, 4'h0, 1'b1, 4'd3, 32'hAA22CC44, 32'hAA22CC44});
        tbl.push_back('{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd3, 32'hAA22CC44, 32'hAA22CC44});
        tbl.push_back('{1'b1, 4'd0, 32'h10,       4'hF, 1'b0, 4'd0, 32'h0, 32'h0});
        tbl.push_back('{1'b1, 4'd1, 32'h20,       4'hF, 1'b0, 4'd0, 32'h0, 32'h0});
        tbl.push_back('{1'b1, 4'd2, 32'h30,       4'hF, 1'b0, 4'd0, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd0, 32'h10, 32'h10});
        tbl.push_back('{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd1, 32'h20, 32'h20});
        tbl.push_back('{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd2, 32'h30, 32'h30});
        tbl.push_back('{1'b1, 4'd5, 32'h12345678, 4'hF, 1'b0, 4'd0, 32'h0, 32'h0});
        tbl.push_back('{1'b1, 4'd5, 32'hFFFFFFFF, 4'h3, 1'b1, 4'd5, 32'h12345678, 32'h1234FFFF});
        tbl.push_back('{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd5, 32'h1234FFFF, 32'h1234FFFF});
        tbl.push_back('{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd2, 32'h30, 32'h30});
        for (int i = 0; i < tbl.size(); i++) begin
            drive(1'b0, tbl[i].we, tbl[i].aa, tbl[i].din, tbl[i].be, tbl[i].re, tbl[i].ba);
            if (tbl[i].re) begin
                cq0.push_back(tbl[i].e0);
                cq1.push_back(tbl[i].e1);
            end
            tick();
        end
        drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        tick(); tick(); tick();
        check("directed_left", 32'(cq0.size() + cq1.size()), 32'd0);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 149) == 0), 1'($urandom), 4'($urandom), $urandom,
                  4'($urandom), 1'($urandom), 4'($urandom));
            tick();
        end
        drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        for (int i = 0; i < 20; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
